alu_share_arbiter: RTL and testbench

//  Shares one integer ALU instance among NUM_REQ requesters (e.g. execute pipe, address-gen, CSR unit).

---
 rtl/rv32i_types.sv | 17 +
 rtl/alu.sv | 25 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/alu_share_arbiter.sv | 76 +++++++
 tb/tb_alu_share_arbiter.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared rv32i types: ALU op encoding and shared-ALU arbiter limits
package rv32i_types;

   typedef enum logic [2:0] {
      alu_add = 3'b000,
      alu_sll = 3'b001,
      alu_sra = 3'b010,
      alu_sub = 3'b011,
      alu_xor = 3'b100,
      alu_srl = 3'b101,
      alu_or  = 3'b110,
      alu_and = 3'b111
   } alu_ops_t;

   localparam int ALU_ARB_MAX_REQ = 8;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 32-bit integer ALU
module alu
   import rv32i_types::*;
(
   input  alu_ops_t    aluop,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] f
);

   always_comb begin
      f = '0;
      unique case (aluop)
         alu_add: f = a + b;
         alu_sll: f = a << b[4:0];
         alu_sra: f = unsigned'($signed(a) >>> b[4:0]);
         alu_sub: f = a - b;
         alu_xor: f = a ^ b;
         alu_srl: f = a >> b[4:0];
         alu_or:  f = a | b;
         alu_and: f = a & b;
      endcase
   end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, priority starts at ptr and wraps
module rr_arbiter #(
   parameter  int N  = 2,
   localparam int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   input  logic          en,
   output logic [N-1:0]  gnt
);

   logic          found;
   logic [PW-1:0] idx;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         idx = PW'((int'(ptr) + k) % N);
         if (en && !found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - one ALU shared by NUM_REQ requesters through a round-robin grant
module alu_share_arbiter
   import rv32i_types::*;
#(
   parameter  int NUM_REQ = 2,
   parameter  int TAG_W   = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic     [NUM_REQ-1:0]          req_valid,
   output logic     [NUM_REQ-1:0]          req_ready,
   input  logic     [NUM_REQ-1:0][31:0]    req_a,
   input  logic     [NUM_REQ-1:0][31:0]    req_b,
   input  alu_ops_t [NUM_REQ-1:0]          req_op,
   input  logic     [NUM_REQ-1:0][TAG_W-1:0] req_tag,
   output logic                            resp_valid,
   input  logic                            resp_ready,
   output logic     [31:0]                 resp_data,
   output logic     [ID_W-1:0]             resp_id,
   output logic     [TAG_W-1:0]            resp_tag
);

   logic [ID_W-1:0]    rr_ptr;
   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    gnt_idx;
   logic               slot_free;
   logic               fire;
   logic [31:0]        alu_f;

   assign slot_free = !resp_valid || resp_ready;

   rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
      .req (req_valid),
      .ptr (rr_ptr),
      .en  (rst_n),
      .gnt (grant)
   );

   // Gating with rst_n keeps req_ready low for the whole reset cycle.
   assign req_ready = grant & {NUM_REQ{slot_free & rst_n}};
   assign fire      = |(req_valid & req_ready);

   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) gnt_idx = ID_W'(i);
      end
   end

   alu u_alu (
      .aluop (req_op[gnt_idx]),
      .a     (req_a[gnt_idx]),
      .b     (req_b[gnt_idx]),
      .f     (alu_f)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_id    <= '0;
         resp_tag   <= '0;
         rr_ptr     <= '0;
      end else if (fire) begin
         resp_valid <= 1'b1;
         resp_data  <= alu_f;
         resp_id    <= gnt_idx;
         resp_tag   <= req_tag[gnt_idx];
         rr_ptr     <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
      end else if (resp_ready) begin
         resp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard bench for alu_share_arbiter with directed vectors
module tb_alu_share_arbiter;
   import rv32i_types::*;

   typedef struct {
      logic [31:0] data;
      logic [31:0] id;
      logic [31:0] tag;
   } exp_t;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic     [1:0]          req_valid;
   logic     [1:0]          req_ready;
   logic     [1:0][31:0]    req_a;
   logic     [1:0][31:0]    req_b;
   alu_ops_t [1:0]          req_op;
   logic     [1:0][3:0]     req_tag;
   logic                    resp_valid;
   logic                    resp_ready;
   logic     [31:0]         resp_data;
   logic     [0:0]          resp_id;
   logic     [3:0]          resp_tag;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t exp_q[$];

   alu_share_arbiter #(.NUM_REQ(2), .TAG_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_op     (req_op),
      .req_tag    (req_tag),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_id    (resp_id),
      .resp_tag   (resp_tag)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] d, input logic [31:0] id, input logic [31:0] tag);
      exp_t e;
      e.data = d;
      e.id   = id;
      e.tag  = tag;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input alu_ops_t op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] tag);
      req_valid[i] = 1'b1;
      req_op[i]    = op;
      req_a[i]     = a;
      req_b[i]     = b;
      req_tag[i]   = tag;
   endtask

   // Monitor: every accepted response is matched against the front of the queue.
   always @(negedge clk) begin
      if (rst_n && resp_valid && resp_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_resp: got data 0x%08h id %0d, want none", resp_data, resp_id);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("resp_data", resp_data, e.data);
            check("resp_id", 32'(resp_id), e.id);
            check("resp_tag", 32'(resp_tag), e.tag);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n      = 1'b0;
      resp_ready = 1'b1;
      req_valid  = 2'b11;
      req_a      = '0;
      req_b      = '0;
      req_op     = {alu_add, alu_add};
      req_tag    = '0;

      // Reset with every requester asking
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("rst_req_ready", 32'(req_ready), 32'h0);
         check("rst_resp_valid", 32'(resp_valid), 32'h0);
         check("rst_resp_data", resp_data, 32'h0);
      end
      tick();
      rst_n     = 1'b1;
      req_valid = 2'b00;

      // Single add from requester 0
      set_req(0, alu_add, 32'd5, 32'd7, 4'd3);
      @(negedge clk);
      check("single_req_ready", 32'(req_ready), 32'h1);
      push_exp(32'd12, 0, 3);
      tick();
      req_valid = 2'b00;
      @(negedge clk);
      check("single_resp_valid", 32'(resp_valid), 32'h1);
      tick();

      // Round-robin, rr_ptr is 1 after the last grant to requester 0
      set_req(0, alu_sub, 32'h0, 32'h1, 4'd1);
      set_req(1, alu_sra, 32'h8000_0000, 32'd4, 4'd2);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k % 2 == 0) begin
            check("rr_req_ready", 32'(req_ready), 32'h2);
            push_exp(32'hF800_0000, 1, 2);
         end else begin
            check("rr_req_ready", 32'(req_ready), 32'h1);
            push_exp(32'hFFFF_FFFF, 0, 1);
         end
         tick();
      end
      req_valid = 2'b00;
      @(negedge clk);
      tick();

      // Backpressure: fire from requester 1, then stall the slot
      set_req(1, alu_xor, 32'hF0F0_0000, 32'h0FF0_0000, 4'd5);
      @(negedge clk);
      check("bp_req_ready", 32'(req_ready), 32'h2);
      push_exp(32'hFF00_0000, 1, 5);
      tick();
      resp_ready = 1'b0;
      set_req(0, alu_and, 32'hFFFF_00FF, 32'h0F0F_0F0F, 4'd6);
      set_req(1, alu_or, 32'h0000_00F0, 32'h0000_0F00, 4'd7);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("stall_req_ready", 32'(req_ready), 32'h0);
         check("stall_resp_valid", 32'(resp_valid), 32'h1);
         check("stall_resp_data", resp_data, 32'hFF00_0000);
         check("stall_resp_tag", 32'(resp_tag), 32'h5);
         tick();
      end
      resp_ready = 1'b1;
      @(negedge clk);
      check("release_req_ready", 32'(req_ready), 32'h1);
      push_exp(32'h0F0F_000F, 0, 6);
      tick();
      req_valid[0] = 1'b0;
      @(negedge clk);
      check("after_release_req_ready", 32'(req_ready), 32'h2);
      push_exp(32'h0000_0FF0, 1, 7);
      tick();
      req_valid = 2'b00;
      @(negedge clk);
      tick();

      // Shift amount uses b[4:0] only
      set_req(0, alu_sll, 32'h1, 32'h21, 4'd8);
      set_req(1, alu_srl, 32'h8000_0000, 32'd31, 4'd9);
      @(negedge clk);
      check("shift0_req_ready", 32'(req_ready), 32'h1);
      push_exp(32'd2, 0, 8);
      tick();
      req_valid[0] = 1'b0;
      @(negedge clk);
      check("shift1_req_ready", 32'(req_ready), 32'h2);
      push_exp(32'd1, 1, 9);
      tick();
      req_valid = 2'b00;
      @(negedge clk);
      tick();

      // Reset while a result is held: it must never be delivered
      resp_ready = 1'b0;
      set_req(0, alu_add, 32'd100, 32'd1, 4'd10);
      @(negedge clk);
      check("midrst_req_ready", 32'(req_ready), 32'h1);
      tick();
      req_valid = 2'b00;
      @(negedge clk);
      check("midrst_held_valid", 32'(resp_valid), 32'h1);
      tick();
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_req_ready_low", 32'(req_ready), 32'h0);
      tick();
      rst_n      = 1'b1;
      resp_ready = 1'b1;
      @(negedge clk);
      check("midrst_resp_valid", 32'(resp_valid), 32'h0);
      // rr_ptr was 1 before reset; a cleared pointer grants requester 0 first
      set_req(0, alu_add, 32'd2, 32'd2, 4'd12);
      set_req(1, alu_add, 32'd1, 32'd1, 4'd11);
      #1;
      check("post_rst_req_ready", 32'(req_ready), 32'h1);
      push_exp(32'd4, 0, 12);
      tick();
      req_valid[0] = 1'b0;
      @(negedge clk);
      check("post_rst_next_ready", 32'(req_ready), 32'h2);
      push_exp(32'd2, 1, 11);
      tick();
      req_valid = 2'b00;

      for (int k = 0; k < 4; k++) tick();
      check("queue_drained", 32'(exp_q.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
